// File: rtl/frac_div_ctrl.sv
// frac_div_ctrl
//   Fractional-N divide controller fed by a 3-stage MASH modulator. Every
//   output period it adds the signed modulator correction to the integer
//   ratio, clamps the sum at MIN_DIV, then counts that many clocks.
//
// State table:
//   state | meaning
//   IDLE  | disabled: counter cleared, strobes low, ratio/clamp held
//   RUN   | counting a period down; reload when the counter reaches 0
//
// Ports:
//   clk_i        single clock, rising edge
//   rstn_i       synchronous active-low reset
//   n_int_i      unsigned integer ratio (sampled at reload)
//   sdm_in_i     signed 4-bit modulator correction, -3..+4 (sampled at reload)
//   en_i         run enable
//   div_pulse_o  high for the first clock of every period
//   div_out_o    divided clock, high for the first ceil(R/2) clocks
//   sdm_req_o    one-clock strobe that advances the modulator
//   ratio_o      ratio R of the current period
//   clamp_o      current R was forced up to MIN_DIV
module frac_div_ctrl #(
  parameter int NW      = 8,
  parameter int MIN_DIV = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [NW-1:0] n_int_i,
  input  logic [3:0]    sdm_in_i,
  input  logic          en_i,
  output logic          div_pulse_o,
  output logic          div_out_o,
  output logic          sdm_req_o,
  output logic [NW:0]   ratio_o,
  output logic          clamp_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic signed [NW+1:0] MIN_S = (NW+2)'(MIN_DIV);
  localparam logic [NW:0]          MIN_R = (NW+1)'(MIN_DIV);
  localparam logic [NW:0]          ONE   = (NW+1)'(1);

  state_t              state_q;
  logic [NW:0]         cnt_q;
  logic [NW:0]         r_cur_q;
  logic                clamp_q;
  logic                pulse_q;
  logic                req_q;

  logic signed [NW+1:0] raw;
  logic [NW:0]          ratio_d;
  logic                 clamp_d;

  // Two extra bits keep both the negative sum (n_int=0, sdm<0) and the
  // maximum 2^NW-1+4 representable.
  always_comb begin
    raw     = $signed({2'b00, n_int_i}) + $signed({{(NW-2){sdm_in_i[3]}}, sdm_in_i});
    clamp_d = (raw < MIN_S);
    ratio_d = clamp_d ? MIN_R : raw[NW:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_cur_q <= '0;
      clamp_q <= 1'b0;
      pulse_q <= 1'b0;
      req_q   <= 1'b0;
    end else if (!en_i) begin
      // Dropping enable wins over a coincident reload; partial period lost.
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      req_q   <= 1'b0;
    end else if (state_q == IDLE || cnt_q == '0) begin
      state_q <= RUN;
      cnt_q   <= ratio_d - ONE;
      r_cur_q <= ratio_d;
      clamp_q <= clamp_d;
      pulse_q <= 1'b1;
      req_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_q - ONE;
      pulse_q <= 1'b0;
      req_q   <= 1'b0;
    end
  end

  // Counter runs R-1..0; values >= floor(R/2) cover ceil(R/2) clocks.
  assign div_out_o   = (state_q == RUN) && (cnt_q >= (r_cur_q >> 1));
  assign div_pulse_o = pulse_q;
  assign sdm_req_o   = req_q;
  assign ratio_o     = r_cur_q;
  assign clamp_o     = clamp_q;

endmodule

// File: tb/tb_frac_div_ctrl.sv
module tb_frac_div_ctrl;

  localparam int NW      = 8;
  localparam int MIN_DIV = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NW-1:0] n_int = '0;
  logic [3:0]    sdm = '0;
  logic          en = 1'b0;
  logic          div_pulse, div_out, sdm_req, clamp;
  logic [NW:0]   ratio;

  int n_checks = 0;
  int n_pass   = 0;

  // period-level reference model: position within the current period
  bit m_run   = 0;
  int m_pos   = 0;
  int m_r     = 0;
  bit m_clamp = 0;

  frac_div_ctrl #(.NW(NW), .MIN_DIV(MIN_DIV)) dut (
    .clk_i(clk), .rstn_i(rstn), .n_int_i(n_int), .sdm_in_i(sdm), .en_i(en),
    .div_pulse_o(div_pulse), .div_out_o(div_out), .sdm_req_o(sdm_req),
    .ratio_o(ratio), .clamp_o(clamp)
  );

  always #5 clk = ~clk;

  wire [NW+4:0] obs = {div_pulse, sdm_req, div_out, clamp, ratio};

  function automatic logic [NW+4:0] exp_vec();
    bit p, d;
    p = m_run && (m_pos == 0);
    d = m_run && (m_pos < (m_r + 1) / 2);
    return {p, p, d, m_clamp, (NW+1)'(m_r)};
  endfunction

  // Applies the rules of one rising edge to the model using the driven inputs.
  task automatic model_edge();
    int raw;
    if (!rstn) begin
      m_run = 0; m_pos = 0; m_r = 0; m_clamp = 0;
    end else if (!en) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run || m_pos == m_r - 1) begin
      raw = int'(n_int) + int'($signed(sdm));
      if (raw < MIN_DIV) begin m_r = MIN_DIV; m_clamp = 1; end
      else begin m_r = raw; m_clamp = 0; end
      m_pos = 0; m_run = 1;
    end else begin
      m_pos++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_sdm(input int v);
    sdm = 4'(v);
  endtask

  task automatic test_reset();
    rstn = 0; en = 1; n_int = 10; set_sdm(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== {(NW+5){1'b0}}) $display("FAIL reset_hold cyc=%0d obs=%h exp=0", i, obs);
      else n_pass++;
    end
    rstn = 1;
    tick();
    n_checks++;
    if (div_pulse !== 1'b1 || ratio !== 9'd10) $display("FAIL reset_first_pulse pulse=%b ratio=%0d exp pulse=1 ratio=10", div_pulse, ratio);
    else n_pass++;
  endtask

  task automatic test_integer();
    int hi, lo;
    hi = 0; lo = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (div_out) hi++; else lo++;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL integer cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      else n_pass++;
    end
    // cycles 2..40 of a 10-period run: four periods less the first pulse cycle
    n_checks++;
    if (hi != 19 || lo != 20) $display("FAIL integer_duty hi=%0d lo=%0d exp 19/20", hi, lo);
    else n_pass++;
  endtask

  task automatic test_frac();
    int sv, cyc, npulse, first, last;
    en = 0; tick();
    sv = 4; n_int = 10; set_sdm(sv); en = 1;
    cyc = 0; npulse = 0; first = 0; last = 0;
    while (npulse < 9 && cyc < 200) begin
      tick();
      cyc++;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL frac cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec());
      else n_pass++;
      if (sdm_req) begin
        npulse++;
        if (npulse == 1) first = cyc;
        last = cyc;
        sv = (sv == 4) ? -3 : 4;
        set_sdm(sv);
      end
    end
    n_checks++;
    if (npulse != 9 || last - first != 84) $display("FAIL frac_span pulses=%0d span=%0d exp 9/84", npulse, last - first);
    else n_pass++;
  endtask

  task automatic test_clamp();
    int per;
    en = 0; tick();
    n_int = 3; set_sdm(-3); en = 1;
    tick();
    n_checks++;
    if (ratio !== 9'd4 || clamp !== 1'b1 || div_pulse !== 1'b1) $display("FAIL clamp_low ratio=%0d clamp=%b exp 4/1", ratio, clamp);
    else n_pass++;
    n_int = 1; set_sdm(4);
    per = 0;
    do begin
      tick(); per++;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL clamp_seq cyc=%0d obs=%h exp=%h", per, obs, exp_vec());
      else n_pass++;
    end while (!div_pulse && per < 10);
    n_checks++;
    if (per != 4 || ratio !== 9'd5 || clamp !== 1'b0) $display("FAIL clamp_edge per=%0d ratio=%0d clamp=%b exp 4/5/0", per, ratio, clamp);
    else n_pass++;
    n_int = 0; set_sdm(-1);
    per = 0;
    do begin tick(); per++; end while (!div_pulse && per < 10);
    n_checks++;
    if (per != 5 || ratio !== 9'd4 || clamp !== 1'b1) $display("FAIL clamp_neg per=%0d ratio=%0d clamp=%b exp 5/4/1", per, ratio, clamp);
    else n_pass++;
  endtask

  task automatic test_max();
    int per, hi;
    en = 0; tick();
    n_int = 255; set_sdm(4); en = 1;
    tick();
    hi = div_out ? 1 : 0;
    per = 0;
    do begin
      tick(); per++;
      if (!div_pulse && div_out) hi++;
    end while (!div_pulse && per < 300);
    n_checks++;
    if (per != 259 || hi != 130 || ratio !== 9'd259) $display("FAIL max per=%0d hi=%0d ratio=%0d exp 259/130/259", per, hi, ratio);
    else n_pass++;
  endtask

  task automatic test_abort();
    int guard;
    en = 0; tick();
    n_int = 10; set_sdm(0); en = 1;
    tick();
    guard = 0;
    while (m_pos != m_r - 4 && guard < 20) begin tick(); guard++; end
    en = 0;
    tick();
    n_checks++;
    if (div_pulse !== 1'b0 || div_out !== 1'b0 || obs !== exp_vec()) $display("FAIL abort_drop pulse=%b dout=%b exp 0/0", div_pulse, div_out);
    else n_pass++;
    tick();
    en = 1;
    tick();
    n_checks++;
    if (div_pulse !== 1'b1 || ratio !== 9'd10) $display("FAIL abort_restart pulse=%b ratio=%0d exp 1/10", div_pulse, ratio);
    else n_pass++;
    for (int i = 0; i < 6; i++) tick();
    rstn = 0;
    tick();
    n_checks++;
    if (ratio !== 9'd0 || div_out !== 1'b0 || div_pulse !== 1'b0) $display("FAIL abort_rst ratio=%0d dout=%b exp 0/0", ratio, div_out);
    else n_pass++;
    rstn = 1;
    tick();
    n_checks++;
    if (div_pulse !== 1'b1 || ratio !== 9'd10 || obs !== exp_vec()) $display("FAIL abort_rst_restart pulse=%b ratio=%0d exp 1/10", div_pulse, ratio);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      n_int = ($urandom % 4 == 0) ? NW'($urandom_range(0, 6)) : NW'($urandom_range(0, 40));
      set_sdm(int'($urandom_range(0, 7)) - 3);
      en   = ($urandom % 60) != 0;
      rstn = ($urandom % 300) != 0;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        errs++;
        if (errs < 10) $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end else n_pass++;
    end
    rstn = 1;
  endtask

  initial begin
    test_reset();
    test_integer();
    test_frac();
    test_clamp();
    test_max();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
